// File: rtl/posicion_rom_param.sv
// Character-cell address generator for the VGA text overlay.
// Writable screen buffer, hardware clear sweep and per-cell blink attribute.
module posicion_rom_param #(
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CODE_W       = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      reloj,
    input  logic                      resetM,
    input  logic [9:0]                Qh,
    input  logic [9:0]                Qv,
    input  logic                      we,
    input  logic [6:0]                wr_col,
    input  logic [4:0]                wr_row,
    input  logic [CODE_W-1:0]         wr_code,
    output logic                      wr_ack,
    input  logic                      clr,
    output logic                      busy,
    input  logic                      frame_tick,
    output logic [19:0]               DIR8x16,
    output logic [$clog2(CHAR_W)-1:0] col_sel,
    output logic                      dir_valid
);

    localparam int CW_L  = $clog2(CHAR_W);
    localparam int CH_L  = $clog2(CHAR_H);
    localparam int N     = COLS * ROWS;
    localparam int IDX_W = $clog2(N);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int AW    = CODE_W - 1 + CH_L;

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sw_idx_q, sw_idx_d;
    logic               sweep_c;

    logic [FC_W-1:0]    fc_q, fc_d;
    logic               phase_q, phase_d;

    logic               ack_q;

    logic [9:0]         mh_c, mv_c;
    logic               in_c;
    logic [IDX_W-1:0]   rd_idx_c;

    logic               s1_v_q, s1_in_q;
    logic [IDX_W-1:0]   s1_idx_q;
    logic [CH_L-1:0]    s1_fila_q;
    logic [CW_L-1:0]    s1_col_q;

    logic               s2_v_q, s2_in_q;
    logic [CH_L-1:0]    s2_fila_q;
    logic [CW_L-1:0]    s2_col_q;
    logic [CODE_W-1:0]  rd_q;

    logic [19:0]        dir_q, dir_d;
    logic [CW_L-1:0]    col_q;
    logic               val_q, val_d;

    logic [CODE_W-1:0]  mem_q [N];
    logic               wr_in_c, acc_c, mem_we_c;
    logic [IDX_W-1:0]   wr_idx_c, mem_widx_c;
    logic [CODE_W-1:0]  mem_wdata_c;

    logic [CODE_W-2:0]  glyph_c;
    logic               show_c;
    logic [AW-1:0]      addr_c;

    // Stage 1 cell mapping; out-of-area pixels read cell 0 and are masked later
    assign mh_c     = Qh >> CW_L;
    assign mv_c     = Qv >> CH_L;
    assign in_c     = (32'(mh_c) < COLS) && (32'(mv_c) < ROWS);
    assign rd_idx_c = in_c ? IDX_W'(mv_c) * IDX_W'(COLS) + IDX_W'(mh_c) : '0;

    assign wr_in_c  = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
    assign wr_idx_c = IDX_W'(wr_row) * IDX_W'(COLS) + IDX_W'(wr_col);
    assign acc_c    = we && !busy && wr_in_c;

    assign mem_we_c    = sweep_c || acc_c;
    assign mem_widx_c  = sweep_c ? sw_idx_q : wr_idx_c;
    assign mem_wdata_c = sweep_c ? '0 : wr_code;

    // Buffer survives reset; NBA read gives read-first behaviour
    always_ff @(posedge reloj) begin
        if (mem_we_c) mem_q[mem_widx_c] <= mem_wdata_c;
        rd_q <= mem_q[s1_idx_q];
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            state_q  <= IDLE;
            sw_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            sw_idx_q <= sw_idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sw_idx_d = sw_idx_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d  = SWEEP;
                    sw_idx_d = '0;
                end
            end
            SWEEP: begin
                if (sw_idx_q == IDX_W'(N - 1)) state_d = IDLE;
                else sw_idx_d = sw_idx_q + IDX_W'(1);
            end
        endcase
    end

    always_comb begin
        sweep_c = (state_q == SWEEP);
        busy    = sweep_c;
    end

    always_comb begin
        fc_d    = fc_q;
        phase_d = phase_q;
        if (frame_tick) begin
            if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
                fc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                fc_d = fc_q + FC_W'(1);
            end
        end
    end

    assign glyph_c = rd_q[CODE_W-2:0];
    assign addr_c  = {glyph_c, s2_fila_q};
    assign show_c  = s2_v_q && s2_in_q && (glyph_c != '0) &&
                     !(rd_q[CODE_W-1] && phase_q);
    assign dir_d   = show_c ? 20'(addr_c) : '0;
    assign val_d   = s2_v_q && s2_in_q;

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            fc_q      <= '0;
            phase_q   <= 1'b0;
            ack_q     <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_in_q   <= 1'b0;
            s1_idx_q  <= '0;
            s1_fila_q <= '0;
            s1_col_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_in_q   <= 1'b0;
            s2_fila_q <= '0;
            s2_col_q  <= '0;
            dir_q     <= '0;
            col_q     <= '0;
            val_q     <= 1'b0;
        end else begin
            fc_q      <= fc_d;
            phase_q   <= phase_d;
            ack_q     <= acc_c;
            s1_v_q    <= 1'b1;
            s1_in_q   <= in_c;
            s1_idx_q  <= rd_idx_c;
            s1_fila_q <= Qv[CH_L-1:0];
            s1_col_q  <= Qh[CW_L-1:0];
            s2_v_q    <= s1_v_q;
            s2_in_q   <= s1_in_q;
            s2_fila_q <= s1_fila_q;
            s2_col_q  <= s1_col_q;
            dir_q     <= dir_d;
            col_q     <= s2_col_q;
            val_q     <= val_d;
        end
    end

    assign wr_ack    = ack_q;
    assign DIR8x16   = dir_q;
    assign col_sel   = col_q;
    assign dir_valid = val_q;

endmodule

// File: tb/tb_posicion_rom_param.sv
// Directed self-checking bench for posicion_rom_param at default parameters.
module tb_posicion_rom_param;

    logic        reloj = 1'b0;
    logic        resetM;
    logic [9:0]  Qh, Qv;
    logic        we;
    logic [6:0]  wr_col;
    logic [4:0]  wr_row;
    logic [7:0]  wr_code;
    logic        wr_ack;
    logic        clr;
    logic        busy;
    logic        frame_tick;
    logic [19:0] DIR8x16;
    logic [2:0]  col_sel;
    logic        dir_valid;

    int n_tests = 0;
    int n_fail  = 0;

    posicion_rom_param dut (
        .reloj(reloj), .resetM(resetM), .Qh(Qh), .Qv(Qv),
        .we(we), .wr_col(wr_col), .wr_row(wr_row), .wr_code(wr_code),
        .wr_ack(wr_ack), .clr(clr), .busy(busy), .frame_tick(frame_tick),
        .DIR8x16(DIR8x16), .col_sel(col_sel), .dir_valid(dir_valid)
    );

    always #5 reloj = ~reloj;

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    task automatic present(input logic [9:0] h, input logic [9:0] v);
        Qh = h;
        Qv = v;
        repeat (3) step();
    endtask

    task automatic do_write(input int c, input int r, input logic [7:0] code);
        wr_col  = 7'(c);
        wr_row  = 5'(r);
        wr_code = code;
        we      = 1'b1;
        step();
        we      = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        resetM = 1'b1;
        Qh = '0; Qv = '0; we = 0; wr_col = '0; wr_row = '0;
        wr_code = '0; clr = 0; frame_tick = 0;
        repeat (2) step();
        n_tests++;
        if (DIR8x16 !== 20'h0) begin
            n_fail++; $display("FAIL reset_dir: got %h want 0", DIR8x16);
        end
        n_tests++;
        if (col_sel !== 3'd0) begin
            n_fail++; $display("FAIL reset_col_sel: got %0d want 0", col_sel);
        end
        n_tests++;
        if (dir_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", dir_valid);
        end
        n_tests++;
        if (wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_ack: got %b want 0", wr_ack);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        resetM = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        do_write(10, 10, 8'h48);
        n_tests++;
        if (wr_ack !== 1'b1) begin
            n_fail++; $display("FAIL wr_ack_pulse: got %b want 1", wr_ack);
        end
        step();
        n_tests++;
        if (wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL wr_ack_single: got %b want 0", wr_ack);
        end
        present(10'd80, 10'd160);
        n_tests++;
        if (DIR8x16 !== 20'h00480 || col_sel !== 3'd0 || dir_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_80_160: got %h/%0d/%b want 00480/0/1",
                     DIR8x16, col_sel, dir_valid);
        end
        present(10'd87, 10'd175);
        n_tests++;
        if (DIR8x16 !== 20'h0048F || col_sel !== 3'd7) begin
            n_fail++;
            $display("FAIL read_87_175: got %h/%0d want 0048f/7", DIR8x16, col_sel);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            Qh = 10'(80 + i);
            Qv = 10'd160;
            step();
            if (i >= 2) begin
                n_tests++;
                if (col_sel !== 3'(i - 2) || DIR8x16 !== 20'h00480) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got %h/%0d want 00480/%0d",
                             i, DIR8x16, col_sel, i - 2);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        Qh = 10'd80;
        Qv = 10'd160;
        @(posedge reloj);
        #3 resetM = 1'b1;
        #1;
        n_tests++;
        if (DIR8x16 !== 20'h0 || dir_valid !== 1'b0 || col_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%b/%0d want 0/0/0",
                     DIR8x16, dir_valid, col_sel);
        end
        #2 resetM = 1'b0;
        step();
        step();
        n_tests++;
        if (dir_valid !== 1'b0) begin
            n_fail++; $display("FAIL refill_early: got %b want 0", dir_valid);
        end
        step();
        n_tests++;
        if (dir_valid !== 1'b1 || DIR8x16 !== 20'h00480) begin
            n_fail++;
            $display("FAIL refill_3cyc: got %h/%b want 00480/1", DIR8x16, dir_valid);
        end
    endtask

    task automatic test_out_of_range();
        do_write(0, 1, 8'h42);
        n_tests++;
        if (wr_ack !== 1'b1) begin
            n_fail++; $display("FAIL oor_ref_ack: got %b want 1", wr_ack);
        end
        do_write(80, 0, 8'h55);
        n_tests++;
        if (wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL oor_col_ack: got %b want 0", wr_ack);
        end
        do_write(0, 30, 8'h55);
        n_tests++;
        if (wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL oor_row_ack: got %b want 0", wr_ack);
        end
        present(10'd0, 10'd16);
        n_tests++;
        if (DIR8x16 !== 20'h00420) begin
            n_fail++; $display("FAIL oor_unchanged: got %h want 00420", DIR8x16);
        end
        present(10'd640, 10'd0);
        n_tests++;
        if (dir_valid !== 1'b0 || DIR8x16 !== 20'h0) begin
            n_fail++;
            $display("FAIL oor_qh640: got %h/%b want 0/0", DIR8x16, dir_valid);
        end
        present(10'd0, 10'd480);
        n_tests++;
        if (dir_valid !== 1'b0 || DIR8x16 !== 20'h0) begin
            n_fail++;
            $display("FAIL oor_qv480: got %h/%b want 0/0", DIR8x16, dir_valid);
        end
    endtask

    task automatic test_clear();
        int cnt;
        do_write(0, 0, 8'h41);
        do_write(79, 29, 8'h41);
        present(10'd632, 10'd464);
        n_tests++;
        if (DIR8x16 !== 20'h00410) begin
            n_fail++; $display("FAIL clr_prefill: got %h want 00410", DIR8x16);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL clr_busy_rise: got %b want 1", busy);
        end
        cnt = 1;
        for (int i = 0; i < 3000 && busy; i++) begin
            if (i == 10) begin
                wr_col = 7'd5; wr_row = 5'd5; wr_code = 8'h33;
                we = 1'b1; clr = 1'b1;
            end
            step();
            if (i == 10) begin
                we = 1'b0; clr = 1'b0;
                n_tests++;
                if (wr_ack !== 1'b0) begin
                    n_fail++; $display("FAIL clr_we_blocked: got %b want 0", wr_ack);
                end
            end
            if (busy) cnt++;
        end
        n_tests++;
        if (cnt != 2400) begin
            n_fail++; $display("FAIL clr_duration: got %0d want 2400", cnt);
        end
        present(10'd0, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h0 || dir_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_cell0: got %h/%b want 0/1", DIR8x16, dir_valid);
        end
        present(10'd632, 10'd464);
        n_tests++;
        if (DIR8x16 !== 20'h0) begin
            n_fail++; $display("FAIL clr_cell2399: got %h want 0", DIR8x16);
        end
    endtask

    task automatic test_blink();
        do_write(0, 0, 8'hC1);
        do_write(1, 0, 8'h41);
        present(10'd0, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h00410) begin
            n_fail++; $display("FAIL blink_on0: got %h want 00410", DIR8x16);
        end
        for (int i = 0; i < 29; i++) begin
            if (i == 5) begin
                wr_col = 7'd2; wr_row = 5'd0; wr_code = 8'h41; we = 1'b1;
            end
            tick();
            if (i == 5) begin
                we = 1'b0;
                n_tests++;
                if (wr_ack !== 1'b1) begin
                    n_fail++; $display("FAIL blink_tick_we_ack: got %b want 1", wr_ack);
                end
            end
        end
        present(10'd0, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h00410) begin
            n_fail++; $display("FAIL blink_on29: got %h want 00410", DIR8x16);
        end
        tick();
        present(10'd0, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h0) begin
            n_fail++; $display("FAIL blink_off30: got %h want 0", DIR8x16);
        end
        present(10'd8, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h00410) begin
            n_fail++; $display("FAIL blink_steady: got %h want 00410", DIR8x16);
        end
        repeat (29) tick();
        present(10'd0, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h0) begin
            n_fail++; $display("FAIL blink_off59: got %h want 0", DIR8x16);
        end
        tick();
        present(10'd0, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h00410) begin
            n_fail++; $display("FAIL blink_on60: got %h want 00410", DIR8x16);
        end
        present(10'd16, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h00410) begin
            n_fail++; $display("FAIL blink_tick_we_data: got %h want 00410", DIR8x16);
        end
    endtask

    task automatic test_reset_mid_sweep();
        repeat (30) tick();
        present(10'd0, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h0) begin
            n_fail++; $display("FAIL rms_phase1: got %h want 0", DIR8x16);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (100) step();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rms_busy_pre: got %b want 1", busy);
        end
        #2 resetM = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rms_busy_reset: got %b want 0", busy);
        end
        #1 resetM = 1'b0;
        do_write(1, 0, 8'hC1);
        n_tests++;
        if (wr_ack !== 1'b1) begin
            n_fail++; $display("FAIL rms_wr_ack: got %b want 1", wr_ack);
        end
        present(10'd8, 10'd0);
        n_tests++;
        if (DIR8x16 !== 20'h00410 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rms_phase0: got %h/%b want 00410/0", DIR8x16, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_reset_midstream();
        test_out_of_range();
        test_clear();
        test_blink();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
